// File: rtl/l2_cache_ctrl.sv
// L2 cache controller: tag/MESI/LRU arrays, L1 request and snoop handling, bus sequencing.
module l2_cache_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SETS   = 16384,
  parameter int unsigned WAYS   = 8,
  parameter int unsigned LINE_B = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [1:0]        resp_snoop,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [1:0]        bus_snoop_in,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  localparam int unsigned OFF_W = $clog2(LINE_B);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned AGE_W = $clog2(WAYS);

  localparam logic [3:0] CMD_RD   = 4'd0;
  localparam logic [3:0] CMD_WR   = 4'd1;
  localparam logic [3:0] CMD_IRD  = 4'd2;
  localparam logic [3:0] CMD_SINV = 4'd3;
  localparam logic [3:0] CMD_SRD  = 4'd4;
  localparam logic [3:0] CMD_SWR  = 4'd5;
  localparam logic [3:0] CMD_SRFO = 4'd6;
  localparam logic [3:0] CMD_CLR  = 4'd8;

  localparam logic [1:0] SNP_HIT   = 2'd0;
  localparam logic [1:0] SNP_HITM  = 2'd1;
  localparam logic [1:0] SNP_NOHIT = 2'd2;

  localparam logic [1:0] BUS_READ = 2'd0;
  localparam logic [1:0] BUS_RFO  = 2'd1;
  localparam logic [1:0] BUS_WB   = 2'd2;
  localparam logic [1:0] BUS_INV  = 2'd3;

  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WB, ST_FILL, ST_UPG, ST_SWB, ST_RESP, ST_CLEAR
  } fsm_t;

  logic [TAG_W-1:0] tag_arr [SETS][WAYS];
  mesi_t            st_arr  [SETS][WAYS];
  logic [AGE_W-1:0] age_arr [SETS][WAYS];

  fsm_t             state;
  logic [3:0]       cmd_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [AGE_W-1:0] way_q;
  logic [IDX_W-1:0] clr_idx;

  logic              hit_c;
  logic [AGE_W-1:0]  hit_way_c;
  logic [AGE_W-1:0]  vic_way_c;
  logic [AGE_W-1:0]  acc_way_c;
  mesi_t             hit_st_c;
  mesi_t             vic_st_c;
  logic [ADDR_W-1:0] line_addr_c;
  logic [ADDR_W-1:0] vic_addr_c;

  // Offset bits of the request address select nothing inside the controller.
  logic unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

  // Tag match and victim choice for the registered set; lowest way wins both.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    vic_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (st_arr[idx_q][w] != MESI_I && tag_arr[idx_q][w] == tag_q) begin
        hit_c     = 1'b1;
        hit_way_c = AGE_W'(w);
      end
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (age_arr[idx_q][w] == AGE_W'(WAYS - 1)) vic_way_c = AGE_W'(w);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (st_arr[idx_q][w] == MESI_I) vic_way_c = AGE_W'(w);
    end
    acc_way_c   = hit_c ? hit_way_c : vic_way_c;
    hit_st_c    = st_arr[idx_q][hit_way_c];
    vic_st_c    = st_arr[idx_q][vic_way_c];
    line_addr_c = {tag_q, idx_q, {OFF_W{1'b0}}};
    vic_addr_c  = {tag_arr[idx_q][vic_way_c], idx_q, {OFF_W{1'b0}}};
  end

  // Controller FSM with registered handshake, bus, stats and array updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_snoop   <= SNP_NOHIT;
      bus_valid    <= 1'b0;
      bus_op       <= BUS_READ;
      bus_addr     <= '0;
      hit_count    <= '0;
      access_count <= '0;
      cmd_q        <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      way_q        <= '0;
      clr_idx      <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_arr[s][w] <= '0;
          st_arr[s][w]  <= MESI_I;
          age_arr[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q     <= req_cmd;
            tag_q     <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q     <= req_addr[OFF_W +: IDX_W];
            req_ready <= 1'b0;
            state     <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          resp_snoop <= SNP_NOHIT;
          way_q      <= acc_way_c;
          case (cmd_q)
            CMD_RD, CMD_WR, CMD_IRD: begin
              resp_hit <= hit_c;
              if (access_count != '1) access_count <= access_count + CNT_W'(1);
              if (hit_c && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
              for (int w = 0; w < int'(WAYS); w++) begin
                if (AGE_W'(w) == acc_way_c)
                  age_arr[idx_q][w] <= '0;
                else if (age_arr[idx_q][w] < age_arr[idx_q][acc_way_c])
                  age_arr[idx_q][w] <= age_arr[idx_q][w] + AGE_W'(1);
              end
              if (hit_c) begin
                if (cmd_q == CMD_WR) begin
                  if (hit_st_c == MESI_S) begin
                    bus_valid  <= 1'b1;
                    bus_op     <= BUS_INV;
                    bus_addr   <= line_addr_c;
                    state      <= ST_UPG;
                    resp_valid <= 1'b0;
                  end else begin
                    st_arr[idx_q][hit_way_c] <= MESI_M;
                  end
                end
              end else if (vic_st_c == MESI_M) begin
                bus_valid  <= 1'b1;
                bus_op     <= BUS_WB;
                bus_addr   <= vic_addr_c;
                state      <= ST_WB;
                resp_valid <= 1'b0;
              end else begin
                bus_valid  <= 1'b1;
                bus_op     <= (cmd_q == CMD_WR) ? BUS_RFO : BUS_READ;
                bus_addr   <= line_addr_c;
                state      <= ST_FILL;
                resp_valid <= 1'b0;
              end
            end
            CMD_SRD, CMD_SRFO: begin
              resp_hit <= hit_c;
              if (hit_c) begin
                if (hit_st_c == MESI_M) begin
                  resp_snoop <= SNP_HITM;
                  bus_valid  <= 1'b1;
                  bus_op     <= BUS_WB;
                  bus_addr   <= line_addr_c;
                  state      <= ST_SWB;
                  resp_valid <= 1'b0;
                end else begin
                  resp_snoop <= SNP_HIT;
                  st_arr[idx_q][hit_way_c] <= (cmd_q == CMD_SRD) ? MESI_S : MESI_I;
                end
              end
            end
            CMD_SINV: begin
              resp_hit <= hit_c;
              if (hit_c && hit_st_c == MESI_S) st_arr[idx_q][hit_way_c] <= MESI_I;
            end
            CMD_SWR: begin
              resp_hit <= hit_c;
            end
            CMD_CLR: begin
              hit_count    <= '0;
              access_count <= '0;
              clr_idx      <= '0;
              state        <= ST_CLEAR;
              resp_valid   <= 1'b0;
            end
            default: ;
          endcase
        end

        ST_WB: begin
          if (bus_ack) begin
            bus_op   <= (cmd_q == CMD_WR) ? BUS_RFO : BUS_READ;
            bus_addr <= line_addr_c;
            state    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (bus_ack) begin
            tag_arr[idx_q][way_q] <= tag_q;
            if (cmd_q == CMD_WR)
              st_arr[idx_q][way_q] <= MESI_M;
            else
              st_arr[idx_q][way_q] <= (bus_snoop_in == SNP_NOHIT) ? MESI_E : MESI_S;
            bus_valid  <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end

        ST_UPG: begin
          if (bus_ack) begin
            st_arr[idx_q][way_q] <= MESI_M;
            bus_valid  <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end

        ST_SWB: begin
          if (bus_ack) begin
            st_arr[idx_q][way_q] <= (cmd_q == CMD_SRD) ? MESI_S : MESI_I;
            bus_valid  <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end

        ST_CLEAR: begin
          for (int w = 0; w < int'(WAYS); w++) begin
            st_arr[clr_idx][w]  <= MESI_I;
            age_arr[clr_idx][w] <= AGE_W'(w);
          end
          if (clr_idx == IDX_W'(SETS - 1)) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_snoop <= SNP_NOHIT;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed scoreboard bench for l2_cache_ctrl with a small 4-set, 2-way geometry.
module tb_l2_cache_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] B_READ = 2'd0, B_RFO = 2'd1, B_WB = 2'd2, B_INV = 2'd3;
  localparam logic [1:0] S_HIT = 2'd0, S_HITM = 2'd1, S_NOHIT = 2'd2;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic [1:0]        resp_snoop;
  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic [1:0]        bus_snoop_in;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  access_count;

  l2_cache_ctrl #(
    .ADDR_W(ADDR_W), .SETS(4), .WAYS(2), .LINE_B(64), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_snoop(resp_snoop),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_snoop_in(bus_snoop_in),
    .hit_count(hit_count), .access_count(access_count)
  );

  typedef struct {
    logic       hit;
    logic [1:0] snoop;
    int         lat;
    int         hits;
    int         accs;
  } resp_exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [1:0]  snp;
  } bus_exp_t;

  resp_exp_t resp_q[$];
  bus_exp_t  bus_q[$];

  int n_vec  = 0;
  int n_err  = 0;
  int n_resp = 0;
  int cyc    = 0;
  int last_c = 0;
  int m_hit  = 0;
  int m_acc  = 0;
  bit hold_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per resp_valid pulse.
  initial begin
    resp_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = resp_q.pop_front();
          check("resp_hit", 64'(resp_hit), 64'(e.hit));
          check("resp_snoop", 64'(resp_snoop), 64'(e.snoop));
          check("hit_count", 64'(hit_count), 64'(e.hits));
          check("access_count", 64'(access_count), 64'(e.accs));
          if (e.lat >= 0) check("resp_latency", 64'(cyc - last_c), 64'(e.lat));
        end
        n_resp++;
      end
    end
  end

  // Bus responder: compares each op on first sight, checks stability, then acks.
  initial begin
    bus_exp_t cur;
    int phase;
    phase = 0;
    bus_ack = 1'b0;
    bus_snoop_in = S_NOHIT;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_ack = 1'b0;
        phase = 0;
      end else if (bus_ack) begin
        bus_ack = 1'b0;
      end else if (bus_valid) begin
        if (phase == 0) begin
          if (bus_q.size() == 0) begin
            check("unexpected_bus_op", 64'(bus_op), 64'hff);
            cur.op = bus_op; cur.addr = bus_addr; cur.snp = S_NOHIT;
          end else begin
            cur = bus_q.pop_front();
            check("bus_op", 64'(bus_op), 64'(cur.op));
            check("bus_addr", 64'(bus_addr), 64'(cur.addr));
          end
          phase = 1;
        end else begin
          check("bus_op_stable", 64'(bus_op), 64'(cur.op));
          check("bus_addr_stable", 64'(bus_addr), 64'(cur.addr));
          if (!hold_ack) begin
            bus_snoop_in = cur.snp;
            bus_ack = 1'b1;
            phase = 0;
          end
        end
      end
    end
  end

  task automatic exp_bus(input logic [1:0] op, input logic [31:0] addr, input logic [1:0] snp);
    bus_exp_t b;
    b.op = op; b.addr = addr; b.snp = snp;
    bus_q.push_back(b);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] addr);
    int i;
    i = 0;
    @(negedge clk);
    while (!req_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    req_cmd   = cmd;
    req_addr  = addr;
    req_valid = 1'b1;
    last_c    = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // lat < 0 means latency depends on bus timing and is not checked.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] addr,
                       input logic hit, input logic [1:0] snp, input int lat);
    resp_exp_t e;
    int target;
    if (cmd <= 4'd2) begin
      m_acc++;
      if (hit) m_hit++;
    end
    if (cmd == 4'd8) begin
      m_acc = 0;
      m_hit = 0;
    end
    e.hit = hit; e.snoop = snp; e.lat = lat; e.hits = m_hit; e.accs = m_acc;
    resp_q.push_back(e);
    target = n_resp + 1;
    drive(cmd, addr);
    for (int i = 0; i < 200 && n_resp < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (n_resp < target) begin
      check("resp_timeout", 64'd0, 64'd1);
      resp_q.delete();
      n_resp = target;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_cmd = '0;
    req_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_resp_snoop", 64'(resp_snoop), 64'(S_NOHIT));
    check("rst_resp_hit", 64'(resp_hit), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_access_count", 64'(access_count), 64'd0);
    rst_n = 1'b1;

    // Cold read, re-read hit, E->M write without bus traffic.
    exp_bus(B_READ, 32'h0000_1040, S_NOHIT);
    issue(4'd0, 32'h0000_1040, 1'b0, S_NOHIT, -1);
    issue(4'd0, 32'h0000_1040, 1'b1, S_NOHIT, 2);
    issue(4'd1, 32'h0000_1040, 1'b1, S_NOHIT, 2);

    // Set 0 pressure: three write tags, LRU victims with writeback.
    exp_bus(B_RFO, 32'h0001_0000, S_NOHIT);
    issue(4'd1, 32'h0001_0000, 1'b0, S_NOHIT, -1);
    exp_bus(B_RFO, 32'h0001_0100, S_NOHIT);
    issue(4'd1, 32'h0001_0100, 1'b0, S_NOHIT, -1);
    exp_bus(B_WB,  32'h0001_0000, S_NOHIT);
    exp_bus(B_RFO, 32'h0001_0200, S_NOHIT);
    issue(4'd1, 32'h0001_0200, 1'b0, S_NOHIT, -1);
    exp_bus(B_WB,   32'h0001_0100, S_NOHIT);
    exp_bus(B_READ, 32'h0001_0000, S_NOHIT);
    issue(4'd0, 32'h0001_0000, 1'b0, S_NOHIT, -1);
    issue(4'd0, 32'h0001_0200, 1'b1, S_NOHIT, 2);
    issue(4'd1, 32'h0001_0000, 1'b1, S_NOHIT, 2);

    // Clear: four sets walked, counters zeroed, M lines dropped silently.
    issue(4'd8, 32'h0000_0000, 1'b0, S_NOHIT, 6);

    // Shared fill then write upgrade.
    exp_bus(B_READ, 32'h0000_2080, S_HIT);
    issue(4'd0, 32'h0000_2080, 1'b0, S_NOHIT, -1);
    exp_bus(B_INV, 32'h0000_2080, S_NOHIT);
    issue(4'd1, 32'h0000_2080, 1'b1, S_NOHIT, -1);

    // Lines present before the clear now miss.
    exp_bus(B_READ, 32'h0000_1040, S_NOHIT);
    issue(4'd0, 32'h0000_1040, 1'b0, S_NOHIT, -1);
    exp_bus(B_READ, 32'h0001_0200, S_HITM);
    issue(4'd0, 32'h0001_0200, 1'b0, S_NOHIT, -1);

    // Snoops on M, S, I and E lines.
    exp_bus(B_WB, 32'h0000_2080, S_NOHIT);
    issue(4'd4, 32'h0000_2080, 1'b1, S_HITM, -1);
    issue(4'd6, 32'h0000_2080, 1'b1, S_HIT, 2);
    issue(4'd4, 32'h0000_2080, 1'b0, S_NOHIT, 2);
    issue(4'd3, 32'h0000_1040, 1'b1, S_NOHIT, 2);
    issue(4'd0, 32'h0000_1040, 1'b1, S_NOHIT, 2);
    issue(4'd3, 32'h0001_0200, 1'b1, S_NOHIT, 2);
    exp_bus(B_READ, 32'h0001_0200, S_NOHIT);
    issue(4'd0, 32'h0001_0200, 1'b0, S_NOHIT, -1);
    issue(4'd5, 32'h0001_0200, 1'b1, S_NOHIT, 2);
    issue(4'd1, 32'h0001_0200, 1'b1, S_NOHIT, 2);
    issue(4'd1, 32'h0001_0200, 1'b1, S_NOHIT, 2);
    exp_bus(B_WB, 32'h0001_0200, S_NOHIT);
    issue(4'd6, 32'h0001_0200, 1'b1, S_HITM, -1);
    exp_bus(B_READ, 32'h0001_0200, S_NOHIT);
    issue(4'd0, 32'h0001_0200, 1'b0, S_NOHIT, -1);

    // Instruction fetch miss, then print and undefined commands as no-ops.
    exp_bus(B_READ, 32'h0000_4000, S_NOHIT);
    issue(4'd2, 32'h0000_4000, 1'b0, S_NOHIT, -1);
    issue(4'd2, 32'h0000_4000, 1'b1, S_NOHIT, 2);
    issue(4'd9, 32'h0000_1040, 1'b0, S_NOHIT, 2);
    issue(4'd7, 32'h0000_1040, 1'b0, S_NOHIT, 2);
    issue(4'd0, 32'h0000_1040, 1'b1, S_NOHIT, 2);

    // Reset while a bus op waits for its ack.
    hold_ack = 1'b1;
    exp_bus(B_READ, 32'h0000_5040, S_NOHIT);
    drive(4'd0, 32'h0000_5040);
    k = 0;
    while (!bus_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bus_valid_before_reset", 64'(bus_valid), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("bus_valid_in_reset", 64'(bus_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_ack = 1'b0;
    m_hit = 0;
    m_acc = 0;
    @(negedge clk);
    check("req_ready_after_reset", 64'(req_ready), 64'd1);
    check("hit_count_after_reset", 64'(hit_count), 64'd0);
    check("access_count_after_reset", 64'(access_count), 64'd0);
    exp_bus(B_READ, 32'h0000_1040, S_NOHIT);
    issue(4'd0, 32'h0000_1040, 1'b0, S_NOHIT, -1);

    repeat (5) @(negedge clk);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
